// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl
//
// Drives one port of a two-port synchronous SRAM macro from a valid/ready
// request stream and returns read data, in request order, through a small
// response queue with backpressure. After every reset the whole array is
// scrubbed to zero before any request is accepted.
//
// Ports
//   clock       block clock, also forwarded to the macro as sram_ce
//   reset_n     asynchronous active-low reset
//   req_*       request stream (write/read, word address, write data)
//   resp_*      read response stream (valid/ready, data)
//   init_done   high once the scrub has finished, until the next reset
//   sram_*      macro pins: ce (clock), csb/web/oeb (active low), a, i, o
//
// Parameters
//   ADDR_W      address width, array depth is 2**ADDR_W
//   DATA_W      data width
//   RESP_DEPTH  response queue entries (>= 1)

module sram_port_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  // request stream
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // response stream
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  // status
  output logic              init_done,
  // macro pins
  output logic              sram_ce,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              init_done_q, init_done_d;
  logic [ADDR_W-1:0] scrub_cnt_q, scrub_cnt_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] resp_mem [RESP_DEPTH];

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occ_sum;
  logic             read_room;
  logic             ready_int;
  logic             wr_accept;
  logic             rd_accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESP_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    // The in-flight read always lands in the queue on the next edge.
    push = inflight_q;
    pop  = (count_q != '0) && resp_ready;

    // Slots already claimed once this edge completes. A pop on this edge
    // frees a slot, which is what lets reads stream at one per cycle with
    // only two queue entries. Without a pop this reduces to plain
    // occupancy + in-flight.
    occ_sum   = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    read_room = occ_sum < (CNT_W + 1)'(RESP_DEPTH);

    ready_int = (state_q == RUN) && (req_write || read_room);
    wr_accept = req_valid && ready_int && req_write;
    rd_accept = req_valid && ready_int && !req_write;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    scrub_cnt_d = scrub_cnt_q;
    inflight_d  = inflight_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    unique case (state_q)
      INIT: begin
        scrub_cnt_d = scrub_cnt_q + ADDR_W'(1);
        if (scrub_cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        // Set by an accepted read; a back-to-back read keeps it set while
        // the previous one is pushed.
        inflight_d = rd_accept;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      init_done_q <= 1'b0;
      scrub_cnt_q <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      scrub_cnt_q <= scrub_cnt_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Queue storage carries no reset: entries are only visible once counted.
  always_ff @(posedge clock) begin
    if (push) begin
      resp_mem[wr_ptr_q] <= sram_o;
    end
  end

  // ---------------------------------------------------------------------
  // Macro pin drive
  // ---------------------------------------------------------------------
  logic              pin_csb;
  logic              pin_web;
  logic              pin_oeb;
  logic [ADDR_W-1:0] pin_a;
  logic [DATA_W-1:0] pin_i;

  always_comb begin
    pin_csb = 1'b1;
    pin_web = 1'b1;
    pin_oeb = 1'b1;
    pin_a   = req_addr;
    pin_i   = req_wdata;
    if (state_q == INIT) begin
      pin_csb = 1'b0;
      pin_web = 1'b0;
      pin_a   = scrub_cnt_q;
      pin_i   = '0;
    end else if (wr_accept) begin
      pin_csb = 1'b0;
      pin_web = 1'b0;
    end else if (rd_accept) begin
      pin_csb = 1'b0;
      pin_oeb = 1'b0;
    end
  end

  // While reset is held the macro must be deselected even though the FSM
  // already sits in INIT (which would otherwise select it for scrubbing).
  assign sram_ce  = clock;
  assign sram_csb = reset_n ? pin_csb : 1'b1;
  assign sram_web = reset_n ? pin_web : 1'b1;
  assign sram_oeb = reset_n ? pin_oeb : 1'b1;
  assign sram_a   = pin_a;
  assign sram_i   = pin_i;

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign req_ready  = ready_int;
  assign resp_valid = (count_q != '0);
  assign resp_rdata = resp_valid ? resp_mem[rd_ptr_q] : '0;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Testbench for sram_port_ctrl: a behavioural macro model sits on the pin
// side, a reference array plus response queue predicts every read result.

module tb_sram_port_ctrl;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int RD = 2;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic          sram_ce;
  logic          sram_csb;
  logic          sram_web;
  logic          sram_oeb;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_i;
  logic [DW-1:0] sram_o;

  always #5 clock = ~clock;

  sram_port_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .RESP_DEPTH(RD)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_ce(sram_ce),
    .sram_csb(sram_csb),
    .sram_web(sram_web),
    .sram_oeb(sram_oeb),
    .sram_a(sram_a),
    .sram_i(sram_i),
    .sram_o(sram_o)
  );

  // Synchronous macro: write or read on the posedge while selected.
  logic [DW-1:0] macro_mem [DEPTH];
  always @(posedge clock) begin
    if (!sram_csb) begin
      if (!sram_web) macro_mem[sram_a] <= sram_i;
      else if (!sram_oeb) sram_o <= macro_mem[sram_a];
    end
  end

  // Reference model
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int scrub_exp = 0;
  int last_acc = 0;
  int last_pop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  // One clock cycle: inspect handshakes at the negedge, return at posedge+1.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clock);
    last_acc = 0;
    last_pop = 0;
    chk("ce_follows_clock", sram_ce, 0);
    if (reset_n && !init_done) begin
      chk("scrub_pins", {sram_csb, sram_web, sram_oeb}, 3'b001);
      chk("scrub_addr", sram_a, scrub_exp);
      chk("scrub_data", sram_i, 0);
      chk("scrub_ready", req_ready, 0);
      scrub_exp++;
    end
    if (reset_n && init_done) begin
      if (req_valid && req_ready) begin
        last_acc = 1;
        if (req_write) begin
          chk("wr_pins", {sram_csb, sram_web, sram_oeb}, 3'b001);
          chk("wr_addr", sram_a, req_addr);
          chk("wr_data", sram_i, req_wdata);
          model_mem[req_addr] = req_wdata;
          $display("write addr=0x%02h data=0x%04h", req_addr, req_wdata);
        end else begin
          chk("rd_pins", {sram_csb, sram_web, sram_oeb}, 3'b010);
          chk("rd_addr", sram_a, req_addr);
          exp_q.push_back(model_mem[req_addr]);
          $display("read  addr=0x%02h", req_addr);
        end
      end else begin
        chk("idle_pins", {sram_csb, sram_web, sram_oeb}, 3'b111);
      end
    end
    if (resp_valid && resp_ready) begin
      last_pop = 1;
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", resp_rdata, e);
        $display("resp  data=0x%04h expected=0x%04h", resp_rdata, e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
    chk("scrub_cycles", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic drain();
    int n = 0;
    drive(1'b0, 1'b0, '0, '0);
    resp_ready = 1'b1;
    while ((exp_q.size() > 0 || resp_valid) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) macro_mem[i] = DW'($urandom);
    reset_n    = 1'b0;
    resp_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_pins", {sram_csb, sram_web, sram_oeb}, 3'b111);
    chk("rst_rdata", resp_rdata, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    scrub_exp = 0;

    // Scrub with a request already pending, then read every address
    drive(1'b1, 1'b0, '0, '0);
    wait_init();
    resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0);
      tick();
      chk("rdall_acc", last_acc, 1);
    end
    drain();

    // Write then read-after-write with latency check
    drive(1'b1, 1'b1, 6'h05, 16'hBEEF);
    tick();
    chk("raw_wr_acc", last_acc, 1);
    drive(1'b1, 1'b0, 6'h05, '0);
    tick();
    chk("raw_rd_acc", last_acc, 1);
    drive(1'b0, 1'b0, '0, '0);
    chk("lat_cycle1", resp_valid, 0);
    tick();
    chk("lat_cycle2", resp_valid, 1);
    tick();
    chk("lat_popped", last_pop, 1);

    // Full queue backpressure
    drive(1'b1, 1'b1, 6'h01, 16'h1111); tick();
    drive(1'b1, 1'b1, 6'h02, 16'h2222); tick();
    drive(1'b1, 1'b1, 6'h03, 16'h3333); tick();
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 6'h01, '0); tick();
    chk("full_rd1_acc", last_acc, 1);
    drive(1'b1, 1'b0, 6'h02, '0); tick();
    chk("full_rd2_acc", last_acc, 1);
    drive(1'b1, 1'b0, 6'h03, '0); tick();
    chk("full_rd3_stall", last_acc, 0);
    tick();
    chk("full_rd3_stall2", last_acc, 0);
    chk("full_ready_low", req_ready, 0);
    drive(1'b1, 1'b1, 6'h10, 16'h1234); tick();
    chk("full_wr_acc", last_acc, 1);
    drive(1'b1, 1'b0, 6'h03, '0);
    resp_ready = 1'b1;
    n = 0;
    last_acc = 0;
    while (last_acc == 0 && n < 10) begin
      tick();
      n++;
    end
    chk("full_rd3_late_acc", last_acc, 1);
    drain();

    // Back-to-back reads over 16 addresses
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, AW'(32 + i), DW'($urandom));
      tick();
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, AW'(32 + i), '0);
      tick();
      chk("b2b_acc", last_acc, 1);
      if (i >= 2) chk("b2b_gap", last_pop, 1);
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();
    chk("b2b_tail1", last_pop, 1);
    tick();
    chk("b2b_tail2", last_pop, 1);
    drain();

    // Reset with two responses queued
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 6'h05, '0); tick();
    drive(1'b1, 1'b0, 6'h21, '0); tick();
    drive(1'b0, 1'b0, '0, '0); tick();
    chk("prerst_valid", resp_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_csb", sram_csb, 1);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_init", init_done, 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    scrub_exp = 0;
    drive(1'b1, 1'b0, 6'h05, '0);
    wait_init();
    resp_ready = 1'b1;
    tick();
    chk("post_rst_acc", last_acc, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
